// File: rtl/vga_fb_reader.sv
// Frame-buffer read stage: walks the 320x240 buffer in raster order, hides the
// buffer read latency and re-aligns sync/blank with RGB888 for the ADV7123 DAC.
module vga_fb_reader #(
    parameter int H_ACT  = 320,
    parameter int V_ACT  = 240,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic              CLK25,
    input  logic              reset,
    input  logic              Hsync_in,
    input  logic              Vsync_in,
    input  logic              Nblank_in,
    input  logic              activeArea,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [11:0]       fb_data,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              Hsync,
    output logic              Vsync,
    output logic              Nblank,
    output logic              frame_done,
    output logic              sync_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACT * V_ACT - 1);

    logic [ADDR_W-1:0] addr;
    logic              vs_prev;

    // Control taps, delayed to match the buffer read latency.
    logic hs_dl  [RD_LAT];
    logic vs_dl  [RD_LAT];
    logic nb_dl  [RD_LAT];
    logic act_dl [RD_LAT];

    assign fb_addr = addr;

    // Vsync resync outranks the active-area increment.
    always_ff @(posedge CLK25) begin
        if (reset) begin
            addr       <= '0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: default low every cycle, so frame_done can only ever be a one-cycle pulse.
            frame_done <= 1'b0;
            if (!Vsync_in) begin
                addr <= '0;
            end else if (activeArea) begin
                if (addr == LAST_ADDR) begin
                    addr       <= '0;
                    frame_done <= 1'b1;
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
            end
        end
    end

    // A frame that restarts with pixels still outstanding is flagged until reset.
    always_ff @(posedge CLK25) begin
        if (reset) begin
            vs_prev  <= 1'b1;
            sync_err <= 1'b0;
        end else begin
            vs_prev <= Vsync_in;
            if (vs_prev && !Vsync_in && (addr != '0))
                sync_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK25) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                hs_dl[i]  <= 1'b1;
                vs_dl[i]  <= 1'b1;
                nb_dl[i]  <= 1'b0;
                act_dl[i] <= 1'b0;
            end
        end else begin
            hs_dl[0]  <= Hsync_in;
            vs_dl[0]  <= Vsync_in;
            nb_dl[0]  <= Nblank_in;
            act_dl[0] <= activeArea;
            for (int i = 1; i < RD_LAT; i++) begin
                hs_dl[i]  <= hs_dl[i-1];
                vs_dl[i]  <= vs_dl[i-1];
                nb_dl[i]  <= nb_dl[i-1];
                act_dl[i] <= act_dl[i-1];
            end
        end
    end

    // Final stage lines up with the buffer data; 4-bit channels replicate to 8 bits.
    always_ff @(posedge CLK25) begin
        if (reset) begin
            vga_r  <= 8'h00;
            vga_g  <= 8'h00;
            vga_b  <= 8'h00;
            Hsync  <= 1'b1;
            Vsync  <= 1'b1;
            Nblank <= 1'b0;
        end else begin
            Hsync  <= hs_dl[RD_LAT-1];
            Vsync  <= vs_dl[RD_LAT-1];
            Nblank <= nb_dl[RD_LAT-1];
            if (act_dl[RD_LAT-1]) begin
                vga_r <= {fb_data[11:8], fb_data[11:8]};
                vga_g <= {fb_data[7:4],  fb_data[7:4]};
                vga_b <= {fb_data[3:0],  fb_data[3:0]};
            end else begin
                vga_r <= 8'h00;
                vga_g <= 8'h00;
                vga_b <= 8'h00;
            end
        end
    end

endmodule
